// File: rtl/qu_common.sv
// qu_common: shared front-end queue defaults, widths and index types.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package qu_common;

    localparam int QU_INSTR_WIDTH    = 32;
    localparam int QU_PC_WIDTH       = 32;

    localparam int QU_FE_ENQ_LANES   = 2;
    localparam int QU_FE_DEQ_LANES   = 2;
    localparam int QU_FE_QUEUE_DEPTH = 16;

    // Index into a default-depth front-end queue.
    localparam int QU_FE_PTR_W = (QU_FE_QUEUE_DEPTH > 1) ? $clog2(QU_FE_QUEUE_DEPTH) : 1;
    typedef logic [QU_FE_PTR_W-1:0] fe_q_ptr_t;

endpackage

// File: rtl/fe_wide_queue_lane_compact.sv
// lane_compact: popcount and exclusive prefix-sum of a sparse lane-valid mask.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the group is accepted.
module lane_compact #(
    parameter int ENQ_LANES = 2,
    localparam int OFF_W = $clog2(ENQ_LANES + 1)
) (
    input  logic [ENQ_LANES-1:0]       valid,
    output logic [ENQ_LANES*OFF_W-1:0] offset,
    output logic [OFF_W-1:0]           total
);

    // Each lane's write offset is the number of valid lanes below it.
    always_comb begin
        logic [OFF_W-1:0] acc;
        acc    = '0;
        offset = '0;
        for (int i = 0; i < ENQ_LANES; i++) begin
            offset[i*OFF_W +: OFF_W] = acc;
            acc = acc + OFF_W'(valid[i]);
        end
        total = acc;
    end

endmodule

// File: rtl/fe_wide_queue.sv
// fe_wide_queue: multi-lane compacting queue between front-end stages (optional QU_FE_QUEUE_BYPASS_EN).
// Latency: enqueue visible on deq_* next cycle; 0 cycles when empty with QU_FE_QUEUE_BYPASS_EN.
// Backpressure: enq_ready from registered count only; a group is accepted whole or dropped.
module fe_wide_queue
    import qu_common::*;
#(
    parameter int DATA_WIDTH = QU_INSTR_WIDTH + QU_PC_WIDTH,
    parameter int DEPTH      = QU_FE_QUEUE_DEPTH,
    parameter int ENQ_LANES  = QU_FE_ENQ_LANES,
    parameter int DEQ_LANES  = QU_FE_DEQ_LANES,
    localparam int CNT_W     = $clog2(DEPTH + 1),
    localparam int TAKE_W    = $clog2(DEQ_LANES + 1)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    input  logic [ENQ_LANES-1:0]            enq_valid,
    input  logic [ENQ_LANES*DATA_WIDTH-1:0] enq_data,
    output logic                            enq_ready,
    output logic [DEQ_LANES-1:0]            deq_valid,
    output logic [DEQ_LANES*DATA_WIDTH-1:0] deq_data,
    input  logic [TAKE_W-1:0]               deq_take,
    output logic [CNT_W-1:0]                count,
    output logic                            empty,
    output logic                            full,
    output logic                            underflow_err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OFF_W = $clog2(ENQ_LANES + 1);
    localparam int SUM_W = CNT_W + 1;

    // Pointer increment modulo DEPTH; inc never exceeds DEPTH so one correction suffices.
    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                                 input logic [CNT_W-1:0] inc);
        logic [SUM_W-1:0] s;
        s = SUM_W'(p) + SUM_W'(inc);
        if (s >= SUM_W'(DEPTH)) begin
            s = s - SUM_W'(DEPTH);
        end
        return s[PTR_W-1:0];
    endfunction

    logic [PTR_W-1:0]           head, tail, head_n, tail_n;
    logic [CNT_W-1:0]           cnt, cnt_n;
    logic [CNT_W-1:0]           n_acc, vis, vis_lanes, take_req, eff_take;
    logic                       fire, over, uerr;
    logic [ENQ_LANES*OFF_W-1:0] offs;
    logic [OFF_W-1:0]           pop;
    logic [ENQ_LANES-1:0]       wr_en;
    logic [PTR_W-1:0]           wr_addr [ENQ_LANES];
    logic [DATA_WIDTH-1:0]      mem [DEPTH];

    lane_compact #(
        .ENQ_LANES (ENQ_LANES)
    ) u_compact (
        .valid  (enq_valid),
        .offset (offs),
        .total  (pop)
    );

    // Room for a full group is judged on registered occupancy, so freed slots reopen next cycle.
    assign enq_ready = (SUM_W'(cnt) + SUM_W'(ENQ_LANES)) <= SUM_W'(DEPTH);
    assign fire      = enq_ready && (|enq_valid) && !flush;
    assign n_acc     = fire ? CNT_W'(pop) : '0;

`ifdef QU_FE_QUEUE_BYPASS_EN
    logic byp;
    assign byp = fire && (cnt == '0);
    assign vis = byp ? n_acc : cnt;
`else
    assign vis = cnt;
`endif

    // Consumer may take at most what is presented; anything more is clamped and flagged.
    assign vis_lanes = (vis > CNT_W'(DEQ_LANES)) ? CNT_W'(DEQ_LANES) : vis;
    assign take_req  = CNT_W'(deq_take);
    assign over      = !flush && (take_req > vis_lanes);
    assign eff_take  = flush ? '0 : (over ? vis_lanes : take_req);

    // Next pointers and occupancy; enqueue and dequeue apply in the same cycle.
    always_comb begin
        head_n = ptr_add(head, eff_take);
        tail_n = ptr_add(tail, n_acc);
        cnt_n  = cnt + n_acc - eff_take;
    end

    // Control state; flush empties the queue but leaves the sticky error alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
            uerr <= 1'b0;
        end else if (flush) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            head <= head_n;
            tail <= tail_n;
            cnt  <= cnt_n;
            uerr <= uerr | over;
        end
    end

    // Valid lanes land at tail + compacted offset; bypass-consumed entries are never stored.
    always_comb begin
        for (int i = 0; i < ENQ_LANES; i++) begin
            wr_en[i]   = fire && enq_valid[i];
            wr_addr[i] = ptr_add(tail, CNT_W'(offs[i*OFF_W +: OFF_W]));
`ifdef QU_FE_QUEUE_BYPASS_EN
            if (byp && (CNT_W'(offs[i*OFF_W +: OFF_W]) < eff_take)) begin
                wr_en[i] = 1'b0;
            end
`endif
        end
    end

    // Storage array is deliberately not reset; only occupancy qualifies its contents.
    always_ff @(posedge clk) begin
        for (int i = 0; i < ENQ_LANES; i++) begin
            if (wr_en[i]) begin
                mem[wr_addr[i]] <= enq_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Read lanes present the oldest entries from head, as a thermometer of occupancy.
    always_comb begin
        deq_data  = '0;
        deq_valid = '0;
        for (int j = 0; j < DEQ_LANES; j++) begin
            deq_valid[j] = vis > CNT_W'(j);
            deq_data[j*DATA_WIDTH +: DATA_WIDTH] = mem[ptr_add(head, CNT_W'(j))];
`ifdef QU_FE_QUEUE_BYPASS_EN
            if (byp) begin
                for (int i = 0; i < ENQ_LANES; i++) begin
                    if (enq_valid[i] && (CNT_W'(offs[i*OFF_W +: OFF_W]) == CNT_W'(j))) begin
                        deq_data[j*DATA_WIDTH +: DATA_WIDTH] = enq_data[i*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
`endif
        end
    end

    assign count         = cnt;
    assign empty         = (cnt == '0);
    assign full          = (cnt == CNT_W'(DEPTH));
    assign underflow_err = uerr;

endmodule

// File: tb/tb_fe_wide_queue.sv
// tb_fe_wide_queue: directed self-checking bench for fe_wide_queue at default parameters.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: exercises full, drop, wrap, flush and underflow cases.
module tb_fe_wide_queue;

    logic         clk;
    logic         rst;
    logic         flush;
    logic [1:0]   enq_valid;
    logic [127:0] enq_data;
    logic         enq_ready;
    logic [1:0]   deq_valid;
    logic [127:0] deq_data;
    logic [1:0]   deq_take;
    logic [4:0]   count;
    logic         empty;
    logic         full;
    logic         underflow_err;

    int checks;
    int failures;

    fe_wide_queue dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .enq_valid     (enq_valid),
        .enq_data      (enq_data),
        .enq_ready     (enq_ready),
        .deq_valid     (deq_valid),
        .deq_data      (deq_data),
        .deq_take      (deq_take),
        .count         (count),
        .empty         (empty),
        .full          (full),
        .underflow_err (underflow_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus; inputs return to idle just after the edge.
    task automatic cyc(input logic [1:0] v, input logic [63:0] d0, input logic [63:0] d1,
                       input logic [1:0] take, input logic fl);
        enq_valid = v;
        enq_data  = {d1, d0};
        deq_take  = take;
        flush     = fl;
        @(posedge clk);
        #1;
        enq_valid = 2'b00;
        enq_data  = '0;
        deq_take  = 2'd0;
        flush     = 1'b0;
    endtask

    function automatic logic [63:0] fv(input int n);
        return 64'hF000 + 64'(n);
    endfunction

    function automatic logic [63:0] wv(input int n);
        return 64'hB000 + 64'(n);
    endfunction

    initial begin
        checks    = 0;
        failures  = 0;
        clk       = 1'b0;
        rst       = 1'b1;
        flush     = 1'b0;
        enq_valid = 2'b00;
        enq_data  = '0;
        deq_take  = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_enq_ready", 64'(enq_ready), 64'd1);
        chk("rst_deq_valid", 64'(deq_valid), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_underflow", 64'(underflow_err), 64'd0);

        // Sparse enqueue on lane 1 only.
        cyc(2'b10, 64'h1111, 64'hA5A5_0001, 2'd0, 1'b0);
        chk("sparse_count", 64'(count), 64'd1);
        chk("sparse_deq_valid", 64'(deq_valid), 64'b01);
        chk("sparse_data0", deq_data[63:0], 64'hA5A5_0001);
        cyc(2'b00, 64'd0, 64'd0, 2'd1, 1'b0);
        chk("sparse_drain_empty", 64'(empty), 64'd1);

        // Fill to DEPTH with two-lane groups.
        for (int k = 0; k < 8; k++) begin
            cyc(2'b11, fv(2 * k), fv(2 * k + 1), 2'd0, 1'b0);
            if (k == 6) begin
                chk("fill14_count", 64'(count), 64'd14);
                chk("fill14_ready", 64'(enq_ready), 64'd1);
            end
        end
        chk("fill_count", 64'(count), 64'd16);
        chk("fill_full", 64'(full), 64'd1);
        chk("fill_ready", 64'(enq_ready), 64'd0);
        cyc(2'b11, 64'hDEAD, 64'hBEEF, 2'd0, 1'b0);
        chk("full_drop_count", 64'(count), 64'd16);
        for (int k = 0; k < 8; k++) begin
            chk("fill_drain_valid", 64'(deq_valid), 64'b11);
            chk("fill_drain_d0", deq_data[63:0], fv(2 * k));
            chk("fill_drain_d1", deq_data[127:64], fv(2 * k + 1));
            cyc(2'b00, 64'd0, 64'd0, 2'd2, 1'b0);
        end
        chk("fill_drain_count", 64'(count), 64'd0);

        // Realign pointers to 0, then build up to tail = 15.
        cyc(2'b00, 64'd0, 64'd0, 2'd0, 1'b1);
        for (int k = 0; k < 7; k++) begin
            cyc(2'b11, wv(2 * k), wv(2 * k + 1), 2'd0, 1'b0);
        end
        cyc(2'b01, wv(14), 64'd0, 2'd0, 1'b0);
        chk("pre15_count", 64'(count), 64'd15);
        chk("pre15_ready", 64'(enq_ready), 64'd0);
        // Not ready at 15 even with a concurrent dequeue: group dropped.
        cyc(2'b11, 64'hBAD0, 64'hBAD1, 2'd1, 1'b0);
        chk("pre15_drop_count", 64'(count), 64'd14);
        for (int k = 0; k < 7; k++) begin
            chk("pre_drain_d0", deq_data[63:0], wv(2 * k + 1));
            chk("pre_drain_d1", deq_data[127:64], wv(2 * k + 2));
            cyc(2'b00, 64'd0, 64'd0, 2'd2, 1'b0);
        end
        chk("pre_drain_empty", 64'(empty), 64'd1);
        // head = tail = 15: first pair straddles index 15 -> 0.
        cyc(2'b11, 64'hC0, 64'hC1, 2'd0, 1'b0);
        cyc(2'b11, 64'hC2, 64'hC3, 2'd0, 1'b0);
        chk("wrap_count", 64'(count), 64'd4);
        chk("wrap_d0", deq_data[63:0], 64'hC0);
        chk("wrap_d1", deq_data[127:64], 64'hC1);
        cyc(2'b00, 64'd0, 64'd0, 2'd2, 1'b0);
        chk("wrap_d2", deq_data[63:0], 64'hC2);
        chk("wrap_d3", deq_data[127:64], 64'hC3);
        cyc(2'b00, 64'd0, 64'd0, 2'd2, 1'b0);
        chk("wrap_empty", 64'(count), 64'd0);

        // Simultaneous enqueue and dequeue at count 3.
        cyc(2'b11, 64'h50, 64'h51, 2'd0, 1'b0);
        cyc(2'b01, 64'h52, 64'd0, 2'd0, 1'b0);
        chk("sim_pre_count", 64'(count), 64'd3);
        cyc(2'b11, 64'h53, 64'h54, 2'd2, 1'b0);
        chk("sim_count", 64'(count), 64'd3);
        chk("sim_d0", deq_data[63:0], 64'h52);
        chk("sim_d1", deq_data[127:64], 64'h53);
        cyc(2'b00, 64'd0, 64'd0, 2'd2, 1'b0);
        chk("sim_tail_count", 64'(count), 64'd1);
        chk("sim_tail_d0", deq_data[63:0], 64'h54);
        chk("sim_tail_valid", 64'(deq_valid), 64'b01);
        cyc(2'b00, 64'd0, 64'd0, 2'd1, 1'b0);

        // Flush with concurrent enqueue and dequeue at count 9.
        for (int k = 0; k < 4; k++) begin
            cyc(2'b11, 64'h70, 64'h71, 2'd0, 1'b0);
        end
        cyc(2'b01, 64'h72, 64'd0, 2'd0, 1'b0);
        chk("flush_pre_count", 64'(count), 64'd9);
        cyc(2'b11, 64'h80, 64'h81, 2'd1, 1'b1);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_empty", 64'(empty), 64'd1);
        chk("flush_deq_valid", 64'(deq_valid), 64'd0);
        chk("flush_ready", 64'(enq_ready), 64'd1);

        // Underflow: take 2 with one entry.
        cyc(2'b01, 64'h90, 64'd0, 2'd0, 1'b0);
        chk("uf_pre_count", 64'(count), 64'd1);
        chk("uf_pre_flag", 64'(underflow_err), 64'd0);
        cyc(2'b00, 64'd0, 64'd0, 2'd2, 1'b0);
        chk("uf_count", 64'(count), 64'd0);
        chk("uf_flag", 64'(underflow_err), 64'd1);
        cyc(2'b00, 64'd0, 64'd0, 2'd0, 1'b1);
        chk("uf_after_flush", 64'(underflow_err), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("uf_after_rst", 64'(underflow_err), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
